prog_sequencer: RTL and testbench

Program feeder that sits directly upstream of the 16-bit multicycle processor. It holds a small loadable program memory and drives the processor's DIN and Run inputs. It follows the processor's Done handshake one instruction at a time and supplies the second word of mvi at the right step. A watchdog flags a processor that never returns Done.

---
 rtl/prog_sequencer.sv | 168 ++++++++++++++++
 tb/tb_prog_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: program feeder for the 16-bit multicycle processor.
// Holds a loadable DEPTH x 16 program memory and steps through it one
// instruction at a time, following the processor's Done handshake. It supplies
// the immediate word of mvi in processor step 1. A watchdog aborts an
// instruction that never returns Done.
//
// Ports:
//   Clock, Resetn        clock, asynchronous active-low reset
//   WrEn/WrAddr/WrData   program write port (accepted only while idle)
//   ProgLen              number of words to execute (clamped to DEPTH)
//   Start                begin execution at address 0
//   Done                 processor end-of-instruction flag
//   DIN, Run             processor instruction/immediate bus and enable
//   Busy                 execution in progress
//   Finished, Error      sticky completion / abort flags
//   PC                   current program address
module prog_sequencer #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned TIMEOUT = 7
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          WrEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [15:0]   WrData,
    input  logic [AW:0]   ProgLen,
    input  logic          Start,
    input  logic          Done,
    output logic [15:0]   DIN,
    output logic          Run,
    output logic          Busy,
    output logic          Finished,
    output logic          Error,
    output logic [AW-1:0] PC
);

    localparam int unsigned LW = AW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [WW-1:0] TIMEOUT_W = WW'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_IMM   = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [15:0]   mem [DEPTH];
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          fin_q, fin_d;
    logic          err_q, err_d;
    logic          run_q, busy_q;
    logic [15:0]   din_q;

    logic [LW-1:0] eff_len;
    logic [LW-1:0] pc_inc;
    logic [WW-1:0] wd_inc;
    logic          is_mvi;
    logic          wr_ok;
    logic [15:0]   rd_word;

    // Effective program length and derived compare terms
    assign eff_len = (ProgLen > DEPTH_L) ? DEPTH_L : ProgLen;
    assign pc_inc  = {1'b0, pc_q} + LW'(1);
    assign wd_inc  = wd_q + WW'(1);
    assign is_mvi  = (mem[pc_q][8:6] == 3'b001);
    assign wr_ok   = WrEn && (state_q == S_IDLE) && ({1'b0, WrAddr} < DEPTH_L);

    // Word DIN will carry next cycle; forwards a write landing on the Start edge
    assign rd_word = (wr_ok && (WrAddr == pc_d)) ? WrData : mem[pc_d];

    // Program memory: synchronous write, never reset
    always_ff @(posedge Clock) begin
        if (wr_ok) begin
            mem[WrAddr] <= WrData;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wd_d    = wd_q;
        fin_d   = fin_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    fin_d = 1'b0;
                    err_d = 1'b0;
                    pc_d  = '0;
                    wd_d  = '0;
                    if (eff_len == '0) begin
                        fin_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wd_d = wd_inc;
                if (is_mvi) begin
                    if (pc_inc < eff_len) begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_IMM;
                    end else begin
                        // mvi without room for its immediate word
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                if (Done) begin
                    if (pc_inc == eff_len) begin
                        fin_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        wd_d    = '0;
                        state_d = S_ISSUE;
                    end
                end else if (wd_inc >= TIMEOUT_W) begin
                    // Watchdog expiry; PC left at the stuck instruction
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_inc;
                end
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            wd_q    <= '0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wd_q    <= wd_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
            run_q   <= (state_d != S_IDLE);
            busy_q  <= (state_d != S_IDLE);
            din_q   <= (state_d != S_IDLE) ? rd_word : 16'h0000;
        end
    end

    assign DIN      = din_q;
    assign Run      = run_q;
    assign Busy     = busy_q;
    assign Finished = fin_q;
    assign Error    = err_q;
    assign PC       = pc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed bench for prog_sequencer with a small behavioural
// model of the multicycle processor (mv/mvi finish in step 1, add/sub in step 3).
module tb_prog_sequencer;

    localparam int unsigned DEPTH   = 24;
    localparam int unsigned AW      = 5;
    localparam int unsigned TIMEOUT = 7;

    logic          Clock, Resetn;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [15:0]   WrData;
    logic [AW:0]   ProgLen;
    logic          Start;
    logic          Done;
    logic [15:0]   DIN;
    logic          Run, Busy, Finished, Error;
    logic [AW-1:0] PC;

    int tests = 0;
    int fails = 0;

    prog_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Resetn(Resetn), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .ProgLen(ProgLen), .Start(Start), .Done(Done),
        .DIN(DIN), .Run(Run), .Busy(Busy), .Finished(Finished),
        .Error(Error), .PC(PC)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Processor model
    logic [15:0] r [8];
    logic [1:0]  tstep;
    logic [15:0] ir;
    logic        attached;
    logic        proc_done;

    assign proc_done = Run &&
        ((tstep == 2'd1 && (ir[8:6] == 3'b000 || ir[8:6] == 3'b001)) ||
         (tstep == 2'd3 && (ir[8:6] == 3'b010 || ir[8:6] == 3'b011)));
    assign Done = attached && proc_done;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tstep <= 2'd0;
            ir    <= 16'h0000;
            for (int i = 0; i < 8; i++) r[i] <= 16'h0000;
        end else if (!Run) begin
            tstep <= 2'd0;
        end else begin
            tstep <= proc_done ? 2'd0 : 2'(tstep + 2'd1);
            case (tstep)
                2'd0: ir <= DIN;
                2'd1: begin
                    if (ir[8:6] == 3'b000) r[ir[5:3]] <= r[ir[2:0]];
                    if (ir[8:6] == 3'b001) r[ir[5:3]] <= DIN;
                end
                2'd3: begin
                    if (ir[8:6] == 3'b010) r[ir[5:3]] <= r[ir[5:3]] + r[ir[2:0]];
                    if (ir[8:6] == 3'b011) r[ir[5:3]] <= r[ir[5:3]] - r[ir[2:0]];
                end
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
        WrEn = 1'b1; WrAddr = a; WrData = d;
        tick();
        WrEn = 1'b0;
    endtask

    task automatic start_prog();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Counts Run-high cycles from the ISSUE just entered until Run drops
    task automatic run_to_idle(output int n, output logic expired);
        n = Run ? 1 : 0;
        expired = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (!Run) begin
                expired = 1'b0;
                break;
            end
            tick();
            if (Run) n++;
        end
    endtask

    initial begin
        logic [15:0] prog [5] = '{16'h0040, 16'h0005, 16'h0048, 16'h0003, 16'h0081};
        int   n;
        logic exp_flag;
        logic found;

        Resetn = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0;
        ProgLen = '0; Start = 1'b0; attached = 1'b1;
        #12;
        check("rst_run", Run, 0);
        check("rst_din", DIN, 0);
        check("rst_busy", Busy, 0);
        check("rst_fin", Finished, 0);
        check("rst_err", Error, 0);
        check("rst_pc", PC, 0);
        Resetn = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) wr(AW'(i), prog[i]);
        for (int i = 5; i < int'(DEPTH); i++) wr(AW'(i), 16'h0012);  // mv r2,r2
        wr(AW'(DEPTH), 16'h0F00);                                     // out of range

        // Main program, with write attempts while busy
        ProgLen = 6'd5;
        start_prog();
        check("t1_issue_din", DIN, 16'h0040);
        check("t1_issue_busy", Busy, 1);
        tick();
        check("t1_imm_din", DIN, 16'h0005);
        check("t1_imm_pc", PC, 1);
        WrEn = 1'b1; WrAddr = 5'd1; WrData = 16'h0007;
        run_to_idle(n, exp_flag);
        WrEn = 1'b0;
        n++;  // first ISSUE cycle was consumed before counting began
        check("t1_bound", exp_flag, 0);
        check("t1_run_cycles", n, 8);
        check("t1_fin", Finished, 1);
        check("t1_err", Error, 0);
        check("t1_pc", PC, 4);
        check("t1_r0", r[0], 16'h0008);
        check("t1_din_idle", DIN, 0);

        // Read-back execution: mem[1] must still be 5
        start_prog();
        tick();
        check("wp_imm_din", DIN, 16'h0005);
        run_to_idle(n, exp_flag);
        check("wp_r0", r[0], 16'h0008);

        // Length clamped to DEPTH
        ProgLen = 6'd30;
        start_prog();
        run_to_idle(n, exp_flag);
        check("clamp_bound", exp_flag, 0);
        check("clamp_run_cycles", n, 46);
        check("clamp_pc", PC, 23);
        check("clamp_fin", Finished, 1);

        // Truncated mvi
        ProgLen = 6'd1;
        start_prog();
        check("trunc_issue_run", Run, 1);
        tick();
        check("trunc_err", Error, 1);
        check("trunc_run", Run, 0);
        check("trunc_fin", Finished, 0);
        check("trunc_pc", PC, 0);

        // Zero-length program
        ProgLen = 6'd0;
        start_prog();
        check("zero_fin", Finished, 1);
        check("zero_err", Error, 0);
        check("zero_run", Run, 0);
        tick();
        check("zero_run2", Run, 0);
        check("zero_busy", Busy, 0);

        // Reset during the WAIT of the add
        ProgLen = 6'd5;
        start_prog();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (PC == 5'd4 && DIN == 16'h0081) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("rmid_reach", found, 1);
        tick();
        check("rmid_wait_run", Run, 1);
        Resetn = 1'b0;
        #1;
        check("rmid_run", Run, 0);
        check("rmid_din", DIN, 0);
        check("rmid_busy", Busy, 0);
        check("rmid_pc", PC, 0);
        #2;
        Resetn = 1'b1;
        tick();
        start_prog();
        run_to_idle(n, exp_flag);
        check("rerun_cycles", n, 8);
        check("rerun_fin", Finished, 1);
        check("rerun_r0", r[0], 16'h0008);

        // Watchdog with the processor detached
        wr(5'd0, 16'h0081);
        attached = 1'b0;
        ProgLen = 6'd1;
        start_prog();
        for (int k = 1; k < int'(TIMEOUT); k++) tick();
        check("wd_pre_err", Error, 0);
        check("wd_pre_run", Run, 1);
        tick();
        check("wd_err", Error, 1);
        check("wd_run", Run, 0);
        check("wd_pc", PC, 0);
        check("wd_fin", Finished, 0);
        check("wd_busy", Busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
